// File: rtl/xadc_drp_sequencer.sv
// XADC DRP sequencer: after each eoc, reads every enabled channel over the DRP
// in ascending order and emits tagged samples. Optional: XADC_OVERRUN_EN adds a sticky overrun flag.
module xadc_drp_sequencer #(
  parameter logic [6:0] CH_ADDR0 = 7'h1f,
  parameter logic [6:0] CH_ADDR1 = 7'h1e,
  parameter logic [6:0] CH_ADDR2 = 7'h17,
  parameter logic [6:0] CH_ADDR3 = 7'h00,
  parameter int         TIMEOUT  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ch_enable,
  input  logic        clear_err,
  input  logic        eoc,
  input  logic        drdy,
  input  logic [15:0] drp_do,
  output logic        den,
  output logic        dwe,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  output logic [15:0] sample_data,
  output logic [1:0]  sample_ch,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
`ifdef XADC_OVERRUN_EN
  ,
  output logic        overrun
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    NEXT    = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_t      state, state_n;
  logic [3:0]  en_q, en_n;
  logic [1:0]  idx, idx_n;
  logic [7:0]  cnt, cnt_n;
  logic        timeout_set;
  logic        capture;
  logic [2:0]  sel;

  function automatic logic [6:0] ch_addr(input logic [1:0] i);
    case (i)
      2'd0:    ch_addr = CH_ADDR0;
      2'd1:    ch_addr = CH_ADDR1;
      2'd2:    ch_addr = CH_ADDR2;
      default: ch_addr = CH_ADDR3;
    endcase
  endfunction

  // Returns {found, index} of the lowest set bit of en at or above start.
  function automatic logic [2:0] first_from(input logic [3:0] en, input logic [2:0] start);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (en[i] && (i >= int'(start))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      en_q  <= 4'b0000;
      idx   <= 2'd0;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      en_q  <= en_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    en_n        = en_q;
    idx_n       = idx;
    cnt_n       = cnt;
    timeout_set = 1'b0;
    capture     = 1'b0;
    sel         = 3'b000;
    case (state)
      IDLE: begin
        if (eoc) begin
          en_n = ch_enable;
          if (ch_enable != 4'b0000) begin
            sel     = first_from(ch_enable, 3'd0);
            idx_n   = sel[1:0];
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_n   = 8'd0;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n = cnt + 8'd1;
        // drdy takes priority over a timeout landing in the same cycle
        if (drdy) begin
          capture = 1'b1;
          state_n = DELIVER;
        end else if (cnt + 8'd1 == TIMEOUT_L) begin
          timeout_set = 1'b1;
          state_n     = NEXT;
        end
      end
      DELIVER: state_n = NEXT;
      NEXT: begin
        sel = first_from(en_q, {1'b0, idx} + 3'd1);
        if (sel[2]) begin
          idx_n   = sel[1:0];
          state_n = ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // daddr is loaded on the way into ISSUE so it is valid with den and held through WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      daddr       <= 7'h00;
      sample_data <= 16'h0000;
      sample_ch   <= 2'd0;
      timeout_err <= 1'b0;
    end else begin
      if (state_n == ISSUE) daddr <= ch_addr(idx_n);
      if (capture) begin
        sample_data <= drp_do;
        sample_ch   <= idx;
      end
      if (timeout_set)    timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

`ifdef XADC_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     overrun <= 1'b0;
    else if (eoc && state != IDLE) overrun <= 1'b1;
    else if (clear_err)            overrun <= 1'b0;
  end
`endif

  assign den          = (state == ISSUE);
  assign sample_valid = (state == DELIVER);
  assign busy         = (state != IDLE);
  assign dwe          = 1'b0;
  assign di           = 16'h0000;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed self-checking bench for xadc_drp_sequencer; checks overrun when XADC_OVERRUN_EN is defined.
module tb_xadc_drp_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ch_enable = 4'b0000;
  logic        clear_err = 1'b0;
  logic        eoc = 1'b0;
  logic        drdy = 1'b0;
  logic [15:0] drp_do = 16'h0000;
  logic        den, dwe, sample_valid, busy, timeout_err;
  logic [6:0]  daddr;
  logic [15:0] di, sample_data;
  logic [1:0]  sample_ch;
`ifdef XADC_OVERRUN_EN
  logic        overrun;
`endif

  int vectors = 0;
  int miscompares = 0;
  int den_cnt = 0;
  int sv_cnt = 0;
  logic [6:0] addr_log[$];
  logic [1:0] ch_log[$];

  xadc_drp_sequencer dut (
    .clk(clk), .reset(reset), .ch_enable(ch_enable), .clear_err(clear_err),
    .eoc(eoc), .drdy(drdy), .drp_do(drp_do), .den(den), .dwe(dwe),
    .daddr(daddr), .di(di), .sample_data(sample_data), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .busy(busy), .timeout_err(timeout_err)
`ifdef XADC_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  // Log every DRP access and delivered sample, away from the active edge.
  always @(negedge clk) begin
    if (den) begin
      den_cnt++;
      addr_log.push_back(daddr);
    end
    if (sample_valid) begin
      sv_cnt++;
      ch_log.push_back(sample_ch);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
    vectors++; if (den !== 1'b0 || dwe !== 1'b0 || sample_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_strobes got den=%b dwe=%b sv=%b want 0", den, dwe, sample_valid); end
    vectors++; if (daddr !== 7'h00 || di !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_drp got daddr=%h di=%h want 00/0000", daddr, di); end
    vectors++; if (sample_data !== 16'h0000 || sample_ch !== 2'd0 || timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_sample got %h/%0d/%b want 0000/0/0", sample_data, sample_ch, timeout_err); end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int d0;
    d0 = den_cnt;
    ch_enable = 4'b0001; eoc = 1'b1;
    tick();
    eoc = 1'b0;
    vectors++; if (den !== 1'b1 || daddr !== 7'h1f || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_issue got den=%b daddr=%h busy=%b want 1/1f/1", den, daddr, busy); end
    tick();
    vectors++; if (den !== 1'b0 || daddr !== 7'h1f) begin miscompares++; $display("[TB] FAIL single_wait got den=%b daddr=%h want 0/1f", den, daddr); end
    tick(); tick();
    drdy = 1'b1; drp_do = 16'hA5B0;
    tick();
    drdy = 1'b0; drp_do = 16'h0000;
    vectors++; if (sample_valid !== 1'b1 || sample_data !== 16'hA5B0 || sample_ch !== 2'd0) begin miscompares++; $display("[TB] FAIL single_sample got sv=%b data=%h ch=%0d want 1/a5b0/0", sample_valid, sample_data, sample_ch); end
    tick();
    vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_sv_width got %b want 0", sample_valid); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy got %b want 0", busy); end
    vectors++; if (den_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL single_den_count got %0d want 1", den_cnt - d0); end
  endtask

  task automatic test_sparse();
    addr_log.delete(); ch_log.delete();
    ch_enable = 4'b1010; eoc = 1'b1;
    tick();
    eoc = 1'b0;
    vectors++; if (den !== 1'b1 || daddr !== 7'h1e) begin miscompares++; $display("[TB] FAIL sparse_first got den=%b daddr=%h want 1/1e", den, daddr); end
    tick(); tick();
    drdy = 1'b1; drp_do = 16'h1110;
    tick();
    drdy = 1'b0;
    vectors++; if (sample_valid !== 1'b1 || sample_ch !== 2'd1 || sample_data !== 16'h1110) begin miscompares++; $display("[TB] FAIL sparse_s1 got sv=%b ch=%0d data=%h want 1/1/1110", sample_valid, sample_ch, sample_data); end
    tick();
    vectors++; if (den !== 1'b0) begin miscompares++; $display("[TB] FAIL sparse_next_den got %b want 0", den); end
    tick();
    vectors++; if (den !== 1'b1 || daddr !== 7'h00) begin miscompares++; $display("[TB] FAIL sparse_second got den=%b daddr=%h want 1/00", den, daddr); end
    tick(); tick();
    drdy = 1'b1; drp_do = 16'h3330;
    tick();
    drdy = 1'b0;
    vectors++; if (sample_valid !== 1'b1 || sample_ch !== 2'd3 || sample_data !== 16'h3330) begin miscompares++; $display("[TB] FAIL sparse_s3 got sv=%b ch=%0d data=%h want 1/3/3330", sample_valid, sample_ch, sample_data); end
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL sparse_busy got %b want 0", busy); end
    vectors++; if (addr_log.size() !== 2 || addr_log[0] !== 7'h1e || addr_log[1] !== 7'h00) begin miscompares++; $display("[TB] FAIL sparse_addrs got n=%0d want 2 accesses 1e,00", addr_log.size()); end
    vectors++; if (ch_log.size() !== 2 || ch_log[0] !== 2'd1 || ch_log[1] !== 2'd3) begin miscompares++; $display("[TB] FAIL sparse_chs got n=%0d want 2 samples 1,3", ch_log.size()); end
  endtask

  task automatic test_timeout();
    int s0;
    s0 = sv_cnt;
    ch_enable = 4'b0011; eoc = 1'b1;
    tick();
    eoc = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    vectors++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL to_early got err=%b busy=%b want 0/1", timeout_err, busy); end
    tick();
    vectors++; if (timeout_err !== 1'b1 || sample_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL to_set got err=%b sv=%b want 1/0", timeout_err, sample_valid); end
    tick();
    vectors++; if (den !== 1'b1 || daddr !== 7'h1e) begin miscompares++; $display("[TB] FAIL to_ch1_issue got den=%b daddr=%h want 1/1e", den, daddr); end
    tick();
    drdy = 1'b1; drp_do = 16'hBEE0;
    tick();
    drdy = 1'b0;
    vectors++; if (sample_valid !== 1'b1 || sample_ch !== 2'd1 || sample_data !== 16'hBEE0) begin miscompares++; $display("[TB] FAIL to_ch1_sample got sv=%b ch=%0d data=%h want 1/1/bee0", sample_valid, sample_ch, sample_data); end
    tick(); tick();
    vectors++; if (sv_cnt - s0 !== 1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL to_samples got %0d busy=%b want 1/0", sv_cnt - s0, busy); end
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL to_sticky got %b want 1", timeout_err); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL to_clear got %b want 0", timeout_err); end
  endtask

  task automatic test_disturb();
    int d0;
`ifdef XADC_OVERRUN_EN
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_initial got %b want 0", overrun); end
`endif
    ch_enable = 4'b0011; eoc = 1'b1;
    tick();
    eoc = 1'b0;
    tick();
    ch_enable = 4'b0000; eoc = 1'b1;
    tick();
    eoc = 1'b0;
    drdy = 1'b1; drp_do = 16'h1111;
    tick();
    drdy = 1'b0;
    vectors++; if (sample_valid !== 1'b1 || sample_ch !== 2'd0) begin miscompares++; $display("[TB] FAIL dist_ch0 got sv=%b ch=%0d want 1/0", sample_valid, sample_ch); end
    tick(); tick();
    vectors++; if (den !== 1'b1 || daddr !== 7'h1e) begin miscompares++; $display("[TB] FAIL dist_ch1_issue got den=%b daddr=%h want 1/1e", den, daddr); end
    tick();
    drdy = 1'b1; drp_do = 16'h2222;
    tick();
    drdy = 1'b0;
    ch_enable = 4'b0011;
    vectors++; if (sample_valid !== 1'b1 || sample_ch !== 2'd1 || sample_data !== 16'h2222) begin miscompares++; $display("[TB] FAIL dist_ch1 got sv=%b ch=%0d data=%h want 1/1/2222", sample_valid, sample_ch, sample_data); end
    d0 = den_cnt;
    tick(); tick(); tick(); tick();
    vectors++; if (busy !== 1'b0 || den_cnt !== d0) begin miscompares++; $display("[TB] FAIL dist_no_rescan got busy=%b extra_den=%0d want 0/0", busy, den_cnt - d0); end
`ifdef XADC_OVERRUN_EN
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_set got %b want 1", overrun); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_clear got %b want 0", overrun); end
`endif
  endtask

  task automatic test_reset_mid();
    int s0;
    ch_enable = 4'b0001; eoc = 1'b1;
    tick();
    eoc = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || den !== 1'b0 || sample_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_ctrl got busy=%b den=%b sv=%b want 0/0/0", busy, den, sample_valid); end
    vectors++; if (daddr !== 7'h00 || sample_data !== 16'h0000 || sample_ch !== 2'd0) begin miscompares++; $display("[TB] FAIL rmid_regs got daddr=%h data=%h ch=%0d want 00/0000/0", daddr, sample_data, sample_ch); end
    tick();
    reset = 1'b0;
    s0 = sv_cnt;
    drdy = 1'b1; drp_do = 16'hDEAD;
    tick();
    drdy = 1'b0;
    tick();
    vectors++; if (sv_cnt !== s0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_late_drdy got samples=%0d busy=%b want 0/0", sv_cnt - s0, busy); end
    ch_enable = 4'b0100; eoc = 1'b1;
    tick();
    eoc = 1'b0;
    vectors++; if (den !== 1'b1 || daddr !== 7'h17) begin miscompares++; $display("[TB] FAIL rmid_rescan got den=%b daddr=%h want 1/17", den, daddr); end
    tick();
    drdy = 1'b1; drp_do = 16'h7770;
    tick();
    drdy = 1'b0;
    vectors++; if (sample_valid !== 1'b1 || sample_ch !== 2'd2 || sample_data !== 16'h7770) begin miscompares++; $display("[TB] FAIL rmid_sample got sv=%b ch=%0d data=%h want 1/2/7770", sample_valid, sample_ch, sample_data); end
    tick(); tick();
  endtask

  task automatic test_empty();
    int d0, s0;
    d0 = den_cnt; s0 = sv_cnt;
    ch_enable = 4'b0000; eoc = 1'b1;
    tick();
    eoc = 1'b0;
    vectors++; if (busy !== 1'b0 || den !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_idle got busy=%b den=%b want 0/0", busy, den); end
    drdy = 1'b1; drp_do = 16'hFFF0;
    tick(); tick();
    drdy = 1'b0;
    tick();
    vectors++; if (sv_cnt !== s0 || den_cnt !== d0 || sample_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_stray got samples=%0d dens=%0d want 0/0", sv_cnt - s0, den_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sparse();
    test_timeout();
    test_disturb();
    test_reset_mid();
    test_empty();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xadc_drp_sequencer.md
Name: xadc_drp_sequencer

Overview:
- Controls the XADC dynamic reconfiguration port (DRP) and shares it among up to four conversion channels.
- After each end-of-conversion pulse, reads every enabled channel's result register over the DRP in ascending index order.
- Delivers each result as a tagged, single-cycle-valid sample to the downstream averaging, scaling and display path.
- Also handles missing DRP responses (timeout) and flags conversions that arrive while a scan is still running.

Parameters:
- CH_ADDR0, 7'h1f, DRP address of channel 0 (VAUX15).
- CH_ADDR1, 7'h1e, DRP address of channel 1 (VAUX14).
- CH_ADDR2, 7'h17, DRP address of channel 2 (VAUX7).
- CH_ADDR3, 7'h00, DRP address of channel 3 (on-chip temperature).
- TIMEOUT, 63, maximum number of WAIT cycles for drdy before the read is abandoned (range 1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ch_enable  in  4  per-channel enable; latched at scan start
- clear_err  in  1  synchronous clear of the sticky flags
- eoc  in  1  XADC end-of-conversion, one-cycle pulse
- drdy  in  1  DRP read data ready
- drp_do  in  16  DRP read data
- den  out  1  DRP enable, one-cycle pulse per access
- dwe  out  1  DRP write enable; always 0
- daddr  out  7  DRP address
- di  out  16  DRP write data; always 16'h0000
- sample_data  out  16  captured DRP word (12-bit result in [15:4])
- sample_ch  out  2  channel index of sample_data
- sample_valid  out  1  one-cycle strobe qualifying sample_data and sample_ch
- busy  out  1  high whenever the state is not IDLE
- timeout_err  out  1  sticky: a read timed out

Behaviour:

Reset (asynchronous, active-high):
- State goes to IDLE.
- den, dwe, sample_valid, busy, timeout_err = 0.
- daddr = 7'h00, di = 16'h0000, sample_data = 16'h0000, sample_ch = 0.
- Internal enable latch, index and timeout counter are cleared.
- Reset asserted mid-scan abandons the scan immediately; no sample_valid is produced for the pending read.

States: IDLE, ISSUE, WAIT, DELIVER, NEXT.

IDLE:
- On eoc=1, latch ch_enable into en_q.
- If ch_enable==0, stay in IDLE.
- Otherwise set idx to the lowest set bit of ch_enable and go to ISSUE.
- drdy is ignored in IDLE.

ISSUE (exactly one cycle):
- den=1, daddr=CH_ADDRidx, dwe=0.
- Clear the timeout counter and go to WAIT.
- Latency: eoc sampled in cycle N gives den=1 in cycle N+1.

WAIT:
- daddr holds its value and den=0. The counter increments every cycle.
- drdy=1: register drp_do into sample_data and idx into sample_ch, then go to DELIVER.
- Counter reaches TIMEOUT with no drdy: set timeout_err and go to NEXT with no sample delivered.
- If drdy arrives in the same cycle the counter reaches TIMEOUT, drdy wins.

DELIVER (one cycle):
- sample_valid=1, then go to NEXT.
- drdy in cycle K gives sample_valid in cycle K+1.

NEXT (one cycle):
- Find the lowest set bit of en_q above idx.
- If one exists, go to ISSUE with the new idx; the next den fires in cycle K+3 relative to the previous drdy.
- If none exists, go to IDLE.

Rules that apply in all states:
- eoc while busy=1 is not queued. The scan completes using the en_q latched at scan start, so ch_enable changes mid-scan have no effect.
- drdy outside WAIT is ignored.
- At most one outstanding DRP access at any time; den never asserts while in WAIT.
- clear_err=1 clears timeout_err. If a set event occurs in the same cycle, the set wins.

Optional Feature:
Macro: XADC_OVERRUN_EN

Defined:
- Adds output port overrun (1 bit, sticky).
- overrun is set when eoc=1 while busy=1.
- Cleared by clear_err, with set winning over clear. Reset value 0.

Undefined:
- No overrun port and no associated logic.
- eoc during a scan is silently dropped.

Test Plan:
1. Single channel: reset, ch_enable=4'b0001, eoc pulse, drdy with drp_do=16'hA5B0 three cycles after den -> den exactly once with daddr=7'h1f; then sample_valid one cycle later with sample_data=16'hA5B0, sample_ch=0; busy returns to 0.
2. Sparse scan: ch_enable=4'b1010, eoc, drdy two cycles after each den -> reads at daddr 7'h1e then 7'h00; sample_ch sequence 1, 3; no access to channels 0 or 2.
3. Timeout: ch_enable=4'b0011, drdy withheld for channel 0 -> after 63 WAIT cycles timeout_err=1 with no sample_valid for channel 0; channel 1 is still read and delivered. A later clear_err pulse returns timeout_err to 0.
4. Mid-scan disturbance: change ch_enable to 4'b0000 during WAIT and pulse eoc during the scan -> the scan finishes using the original enables. With XADC_OVERRUN_EN defined, overrun=1; undefined, no extra scan starts.
5. Reset mid-operation: assert reset during WAIT -> all outputs at their reset values asynchronously. A late drdy after reset deasserts produces no sample_valid; the next eoc starts a clean scan.
6. Empty enable and stray drdy: ch_enable=0 with eoc -> no den and busy stays 0; drdy pulses in IDLE -> sample_valid stays 0.
